box_projection_scheduler: RTL and testbench

- Shares one centered-box projection unit among NUM_REQ requesters, typically the check-node update lanes of the ADMM-LP decoder.
- Arbitrates round-robin and prepends the requester ID to the tag for each accepted vector, then issues it to the unit.
- Routes each projected result back to its owner using that ID.
- Bounds the number of in-flight vectors, so the unit is never driven beyond its pipeline depth plus one response slot.

---
 rtl/box_projection_scheduler_pkg.sv | 26 ++
 rtl/box_projection_scheduler_arbiter.sv | 35 +++
 rtl/box_projection_scheduler.sv | 154 +++++++++++++++
 tb/tb_box_projection_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/box_projection_scheduler_pkg.sv
// Shared helpers for the box-projection scheduler:
// default sizing, clog2 and {id, tag} field layout.
package box_projection_scheduler_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TAG_WIDTH   = 32;
    localparam int DEF_BLOCKLENGTH = 1;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_MAX_OUTST   = 3;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // The user tag sits in the LSBs; the requester ID sits above it.
    function automatic int id_lsb(input int tag_width);
        return tag_width;
    endfunction

endpackage

// File: rtl/box_projection_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or
// after the pointer wins; the pointer itself lives in the parent.
module box_projection_scheduler_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_oh_o,
    output logic [ID_WIDTH-1:0] gnt_id_o,
    output logic                gnt_valid_o
);

    logic [NUM_REQ-1:0] rot;
    logic [ID_WIDTH:0]  sum;

    // Rotate requests so bit 0 is the pointer, pick lowest set bit.
    always_comb begin
        rot         = NUM_REQ'({req_i, req_i} >> ptr_i);
        sum         = '0;
        gnt_valid_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum         = {1'b0, ptr_i} + (ID_WIDTH+1)'(k);
                gnt_valid_o = 1'b1;
            end
        end
        if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
            sum = sum - (ID_WIDTH+1)'(NUM_REQ);
        end
        gnt_id_o = sum[ID_WIDTH-1:0];
        gnt_oh_o = gnt_valid_o ? (NUM_REQ'(1) << gnt_id_o) : '0;
    end

endmodule

// File: rtl/box_projection_scheduler.sv
// Shares one box projection unit among NUM_REQ requesters:
// round-robin issue with ID-tagging, bounded in-flight, routed results.
module box_projection_scheduler
    import box_projection_scheduler_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int ID_WIDTH        = clog2(NUM_REQ),
    parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter int BLOCKLENGTH     = DEF_BLOCKLENGTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTST
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]            req_tag,
    input  logic [NUM_REQ*DATA_WIDTH*BLOCKLENGTH-1:0] req_data,
    output logic                                    pu_valid,
    input  logic                                    pu_busy,
    output logic [TAG_WIDTH+ID_WIDTH-1:0]           pu_tag,
    output logic [DATA_WIDTH*BLOCKLENGTH-1:0]       pu_data,
    output logic                                    pu_ready,
    input  logic                                    pu_valid_out,
    input  logic [TAG_WIDTH+ID_WIDTH-1:0]           pu_tag_out,
    input  logic [DATA_WIDTH*BLOCKLENGTH-1:0]       pu_data_out,
    output logic [NUM_REQ-1:0]                      rsp_valid,
    input  logic [NUM_REQ-1:0]                      rsp_ready,
    output logic [TAG_WIDTH-1:0]                    rsp_tag,
    output logic [DATA_WIDTH*BLOCKLENGTH-1:0]       rsp_data
);

    localparam int TW     = TAG_WIDTH + ID_WIDTH;
    localparam int VW     = DATA_WIDTH * BLOCKLENGTH;
    localparam int CW     = clog2(MAX_OUTSTANDING + 1);
    localparam int ID_LSB = id_lsb(TAG_WIDTH);

    logic                iss_vld_q, iss_vld_d;
    logic [TW-1:0]       iss_tag_q, iss_tag_d;
    logic [VW-1:0]       iss_dat_q, iss_dat_d;
    logic                rsp_vld_q, rsp_vld_d;
    logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
    logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
    logic [VW-1:0]       rsp_dat_q, rsp_dat_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  gnt_oh;
    logic [ID_WIDTH-1:0] gnt_id;
    logic                gnt_v;
    logic                pu_xfer;
    logic                slot_free;
    logic                can_acc;
    logic                accept;
    logic                handoff;
    logic                rsp_load;

    box_projection_scheduler_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .gnt_oh_o    (gnt_oh),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_v)
    );

    // Handshake decode for issue, acceptance and result paths.
    always_comb begin
        pu_xfer   = iss_vld_q & ~pu_busy;
        slot_free = ~iss_vld_q | pu_xfer;
        can_acc   = slot_free & ~reset &
                    (cnt_q < CW'(MAX_OUTSTANDING));
        req_ready = can_acc ? gnt_oh : '0;
        accept    = can_acc & gnt_v;
        handoff   = rsp_vld_q & rsp_ready[rsp_id_q];
        pu_ready  = ~rsp_vld_q | handoff;
        rsp_load  = pu_valid_out & pu_ready;
        pu_valid  = iss_vld_q;
        pu_tag    = iss_vld_q ? iss_tag_q : '0;
        pu_data   = iss_vld_q ? iss_dat_q : '0;
        rsp_valid = rsp_vld_q ? (NUM_REQ'(1) << rsp_id_q) : '0;
        rsp_tag   = rsp_vld_q ? rsp_tag_q : '0;
        rsp_data  = rsp_vld_q ? rsp_dat_q : '0;
    end

    // Next-state for issue/response registers, pointer and counter.
    always_comb begin
        iss_vld_d = iss_vld_q;
        iss_tag_d = iss_tag_q;
        iss_dat_d = iss_dat_q;
        rsp_vld_d = rsp_vld_q;
        rsp_id_d  = rsp_id_q;
        rsp_tag_d = rsp_tag_q;
        rsp_dat_d = rsp_dat_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (pu_xfer) begin
            iss_vld_d = 1'b0;
        end
        if (accept) begin
            iss_vld_d = 1'b1;
            iss_tag_d = {gnt_id,
                         req_tag[gnt_id*TAG_WIDTH +: TAG_WIDTH]};
            iss_dat_d = req_data[gnt_id*VW +: VW];
            if (gnt_id == ID_WIDTH'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + ID_WIDTH'(1);
            end
        end
        if (handoff) begin
            rsp_vld_d = 1'b0;
        end
        if (rsp_load) begin
            rsp_vld_d = 1'b1;
            rsp_id_d  = pu_tag_out[ID_LSB +: ID_WIDTH];
            rsp_tag_d = pu_tag_out[TAG_WIDTH-1:0];
            rsp_dat_d = pu_data_out;
        end
        if (accept && !handoff) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && handoff) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_vld_q <= 1'b0;
            iss_tag_q <= '0;
            iss_dat_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_tag_q <= '0;
            rsp_dat_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            iss_vld_q <= iss_vld_d;
            iss_tag_q <= iss_tag_d;
            iss_dat_q <= iss_dat_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_tag_q <= rsp_tag_d;
            rsp_dat_q <= rsp_dat_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_box_projection_scheduler.sv
// Bench for box_projection_scheduler with a 2-stage stallable
// projection unit model and a queue-based reference scoreboard.
module tb_box_projection_scheduler;

    localparam int N    = 4;
    localparam int TAGW = 32;
    localparam int IDW  = 2;
    localparam int DW   = 8;
    localparam int MAXO = 3;
    localparam int TW   = TAGW + IDW;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*TAGW-1:0] req_tag;
    logic [N*DW-1:0]   req_data;
    logic          pu_valid;
    logic          pu_busy;
    logic [TW-1:0] pu_tag;
    logic [DW-1:0] pu_data;
    logic          pu_ready;
    logic          pu_valid_out;
    logic [TW-1:0] pu_tag_out;
    logic [DW-1:0] pu_data_out;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [TAGW-1:0] rsp_tag;
    logic [DW-1:0] rsp_data;

    logic busy_force;

    always #5 clk = ~clk;

    box_projection_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_tag      (req_tag),
        .req_data     (req_data),
        .pu_valid     (pu_valid),
        .pu_busy      (pu_busy),
        .pu_tag       (pu_tag),
        .pu_data      (pu_data),
        .pu_ready     (pu_ready),
        .pu_valid_out (pu_valid_out),
        .pu_tag_out   (pu_tag_out),
        .pu_data_out  (pu_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_tag      (rsp_tag),
        .rsp_data     (rsp_data)
    );

    // Projection unit model: in-order 2-stage pipe, echoes tag/data.
    logic          u1v, u2v;
    logic [TW-1:0] u1t, u2t;
    logic [DW-1:0] u1d, u2d;
    logic          stall;

    assign stall        = u2v && !pu_ready;
    assign pu_busy      = busy_force || (stall && u1v);
    assign pu_valid_out = u2v;
    assign pu_tag_out   = u2t;
    assign pu_data_out  = u2d;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            u1v <= 1'b0; u2v <= 1'b0;
            u1t <= '0;   u2t <= '0;
            u1d <= '0;   u2d <= '0;
        end else begin
            if (!stall) begin
                u2v <= u1v; u2t <= u1t; u2d <= u1d;
            end
            if (!stall || !u1v) begin
                u1v <= pu_valid && !pu_busy;
                u1t <= pu_tag;
                u1d <= pu_data;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [31:0] tag;
        logic [7:0]  data;
    } ent_t;

    ent_t iss_q[$];
    ent_t ord_q[$];
    ent_t rsp_q[$];
    int   ptr_m;
    int   out_m;
    bit   bump;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] rdy;
    } row_t;
    row_t tab[11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_clear();
        iss_q.delete();
        ord_q.delete();
        rsp_q.delete();
        ptr_m = 0;
        out_m = 0;
    endfunction

    // One clock of the reference model: check at negedge, update
    // at posedge, return 1 time unit after the edge.
    task automatic step(input bit use_exp, input logic [3:0] exp_tab);
        int          g;
        bit          anyv, acc, xfer, hand, load;
        logic [3:0]  er;
        logic [TW-1:0] et;
        logic [DW-1:0] ed;
        ent_t        e, r, a;
        @(negedge clk);
        anyv = 0;
        g    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(ptr_m + k) % N]) begin
                anyv = 1;
                g    = (ptr_m + k) % N;
            end
        end
        acc  = anyv && (iss_q.size() == 0 || !pu_busy)
               && out_m < MAXO;
        er   = acc ? 4'(1 << g) : 4'b0;
        xfer = iss_q.size() != 0 && !pu_busy;
        hand = rsp_q.size() != 0 && rsp_ready[rsp_q[0].id];
        load = pu_valid_out && (rsp_q.size() == 0 || hand);
        a.id   = g;
        a.tag  = req_tag[g*TAGW +: TAGW];
        a.data = req_data[g*DW +: DW];
        if (use_exp) chk("table_ready", 64'(req_ready), 64'(exp_tab));
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("pu_valid", 64'(pu_valid), 64'(iss_q.size()));
        et = '0;
        ed = '0;
        if (iss_q.size() != 0) begin
            et = {IDW'(iss_q[0].id), iss_q[0].tag};
            ed = iss_q[0].data;
        end
        chk("pu_tag", 64'(pu_tag), 64'(et));
        chk("pu_data", 64'(pu_data), 64'(ed));
        chk("pu_ready", 64'(pu_ready),
            64'(rsp_q.size() == 0 || hand));
        if (rsp_q.size() != 0) begin
            chk("rsp_valid", 64'(rsp_valid), 64'(1 << rsp_q[0].id));
            chk("rsp_tag", 64'(rsp_tag), 64'(rsp_q[0].tag));
            chk("rsp_data", 64'(rsp_data), 64'(rsp_q[0].data));
        end else begin
            chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
        end
        r.id   = int'(pu_tag_out[TW-1 -: IDW]);
        r.tag  = pu_tag_out[TAGW-1:0];
        r.data = pu_data_out;
        if (load) begin
            checks++;
            if (ord_q.size() == 0) begin
                errors++;
                $display("FAIL stray_result: got %0h expected none",
                         pu_tag_out);
            end else begin
                e = ord_q.pop_front();
                if (r.id != e.id || r.tag != e.tag
                    || r.data != e.data) begin
                    errors++;
                    $display("FAIL issue_order: got %0h/%0h expected %0h/%0h",
                             pu_tag_out, r.data,
                             {IDW'(e.id), e.tag}, e.data);
                end
            end
        end
        @(posedge clk);
        if (hand) begin
            void'(rsp_q.pop_front());
            out_m--;
        end
        if (load) rsp_q.push_back(r);
        if (xfer) void'(iss_q.pop_front());
        if (acc) begin
            iss_q.push_back(a);
            ord_q.push_back(a);
            out_m++;
            ptr_m = (g + 1) % N;
        end
        #1;
        if (acc && bump) begin
            req_tag[g*TAGW +: TAGW] = req_tag[g*TAGW +: TAGW] + 1;
            req_data[g*DW +: DW]    = req_data[g*DW +: DW] + 1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        busy_force = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_tag    = '0;
        req_data   = '0;
        rsp_ready  = '0;
        busy_force = 1'b0;
        bump       = 1'b0;
        model_clear();

        tab[0]  = '{4'hF, 4'b0001};
        tab[1]  = '{4'hF, 4'b0010};
        tab[2]  = '{4'hF, 4'b0100};
        tab[3]  = '{4'hF, 4'b0000};
        tab[4]  = '{4'hF, 4'b0000};
        tab[5]  = '{4'hF, 4'b1000};
        tab[6]  = '{4'hF, 4'b0001};
        tab[7]  = '{4'hF, 4'b0010};
        tab[8]  = '{4'hF, 4'b0000};
        tab[9]  = '{4'hF, 4'b0000};
        tab[10] = '{4'hF, 4'b0100};

        // Reset state with all inputs low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pu_valid", 64'(pu_valid), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_pu_tag", 64'(pu_tag), 0);
        chk("rst_pu_data", 64'(pu_data), 0);
        chk("rst_rsp_tag", 64'(rsp_tag), 0);
        chk("rst_rsp_data", 64'(rsp_data), 0);
        reset = 1'b0;
        #1;
        chk("rel_pu_ready", 64'(pu_ready), 1);
        chk("rel_cnt", 64'(dut.cnt_q), 0);
        chk("rel_ptr", 64'(dut.ptr_q), 0);
        chk("rel_pu_valid", 64'(pu_valid), 0);

        // Single requester 2, latency to response.
        rsp_ready = 4'hF;
        req_valid = 4'b0100;
        req_tag[2*TAGW +: TAGW] = 32'h11;
        req_data[2*DW +: DW]    = 8'h40;
        step(1, 4'b0100);
        req_valid = '0;
        chk("single_pu_valid", 64'(pu_valid), 1);
        chk("single_pu_tag", 64'(pu_tag), 64'({2'd2, 32'h11}));
        step(0, '0);
        step(0, '0);
        chk("single_t3_rsp", 64'(rsp_valid), 0);
        step(0, '0);
        chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("single_rsp_tag", 64'(rsp_tag), 64'(32'h11));
        chk("single_rsp_data", 64'(rsp_data), 64'(8'h40));
        repeat (3) step(0, '0);

        // Round-robin with all four requesting, limit 3 in flight.
        do_reset();
        rsp_ready = 4'hF;
        req_tag   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 11; i++) begin
            req_valid = tab[i].vld;
            step(1, tab[i].rdy);
        end
        req_valid = '0;
        repeat (8) step(0, '0);

        // Issue register held while the unit is busy.
        do_reset();
        req_tag[0 +: TAGW] = 32'hC0;
        req_data[0 +: DW]  = 8'h5A;
        req_valid = 4'b0001;
        step(1, 4'b0001);
        busy_force = 1'b1;
        req_valid  = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            chk("busy_hold_tag", 64'(pu_tag), 64'({2'd0, 32'hC0}));
            chk("busy_hold_data", 64'(pu_data), 64'(8'h5A));
            step(1, 4'b0000);
        end
        busy_force = 1'b0;
        step(1, 4'b0010);
        req_valid = '0;
        repeat (8) step(0, '0);

        // Result back-pressure on requester 1.
        do_reset();
        bump = 1'b1;
        req_tag[TAGW +: TAGW] = 32'hB0;
        req_data[DW +: DW]    = 8'h70;
        req_valid = 4'b0010;
        rsp_ready = 4'b1101;
        repeat (4) step(0, '0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_pu_ready", 64'(pu_ready), 0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
            chk("bp_rsp_tag", 64'(rsp_tag), 64'(32'hB0));
            chk("bp_cnt", 64'(dut.cnt_q), 64'(MAXO));
            step(0, '0);
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        bump      = 1'b0;
        repeat (12) step(0, '0);
        chk("bp_drained_cnt", 64'(dut.cnt_q), 0);

        // Reset with three vectors in flight.
        do_reset();
        req_valid = 4'b0111;
        repeat (3) step(0, '0);
        reset     = 1'b1;
        req_valid = '0;
        model_clear();
        #1;
        chk("mid_rst_pu_valid", 64'(pu_valid), 0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 0);
        chk("mid_rst_req_ready", 64'(req_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_cnt", 64'(dut.cnt_q), 0);
        repeat (8) step(0, '0);

        // Randomized traffic against the scoreboard.
        do_reset();
        bump = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            req_valid  = 4'($urandom);
            rsp_ready  = 4'($urandom) | 4'($urandom);
            busy_force = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req_tag  = {$urandom, $urandom, $urandom, $urandom};
                req_data = $urandom;
            end
            step(0, '0);
        end
        req_valid  = '0;
        rsp_ready  = 4'hF;
        busy_force = 1'b0;
        repeat (12) step(0, '0);
        chk("rand_drained_cnt", 64'(dut.cnt_q), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
